// File: rtl/sha256d_sequencer.sv
// Host-side sequencer for the SHA-256 compression core: owns the H/M banks and K ROM,
// serves the core's read addresses, captures its stores and runs the nine-command SHA256d flow.
module sha256d_sequencer #(
  parameter logic [7:0]  CMD_IDLE        = 8'd0,
  parameter logic [7:0]  CMD_LOAD_H      = 8'd1,
  parameter logic [7:0]  CMD_HASH        = 8'd2,
  parameter logic [7:0]  CMD_SUM_STORE_H = 8'd3,
  parameter logic [7:0]  CMD_SUM_STORE_M = 8'd4,
  parameter logic [7:0]  CMD_GET_DIGEST  = 8'd5,
  parameter int unsigned TIMEOUT_CYC     = 1024
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         HDR_WE,
  input  logic [4:0]   HDR_ADDR,
  input  logic [31:0]  HDR_DATA,
  input  logic         START,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [255:0] DIGEST,
  output logic [7:0]   CMD,
  input  logic [7:0]   MKA,
  input  logic [7:0]   HA,
  output logic [31:0]  MD_IN,
  output logic [31:0]  KD,
  output logic [31:0]  HD_IN,
  input  logic [31:0]  HD_OUT,
  input  logic [31:0]  MD_OUT,
  input  logic [255:0] RES,
  input  logic         RDY
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_RST [24] = '{
    0: 32'h6a09e667, 1: 32'hbb67ae85, 2: 32'h3c6ef372, 3: 32'ha54ff53a,
    4: 32'h510e527f, 5: 32'h9b05688c, 6: 32'h1f83d9ab, 7: 32'h5be0cd19,
    default: 32'h0
  };

  // Padding words for the 80-byte header block (M[16..31]) and the 32-byte digest block (M[32..47]).
  localparam logic [31:0] M_RST [48] = '{
    20: 32'h80000000, 31: 32'h00000280,
    40: 32'h80000000, 47: 32'h00000100,
    default: 32'h0
  };

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_H1, S_HASH1, S_SUM1, S_LOAD_H2, S_HASH2,
    S_SUM2, S_LOAD_H3, S_HASH3, S_DIGEST, S_ERR
  } state_e;

  typedef enum logic {PH_ISSUE, PH_RELEASE} phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [255:0]       digest_q, digest_d;
  logic [31:0]        h_q [24];
  logic [31:0]        m_q [48];
  logic [7:0]         cmd_code;
  logic [1:0]         m_sel;
  logic               h_sel;
  logic               unused_addr_bits;

  function automatic state_e succ(input state_e s);
    case (s)
      S_LOAD_H1: return S_HASH1;
      S_HASH1:   return S_SUM1;
      S_SUM1:    return S_LOAD_H2;
      S_LOAD_H2: return S_HASH2;
      S_HASH2:   return S_SUM2;
      S_SUM2:    return S_LOAD_H3;
      S_LOAD_H3: return S_HASH3;
      S_HASH3:   return S_DIGEST;
      default:   return S_IDLE;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_ISSUE;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
      digest_q <= digest_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tmo_d    = tmo_q + TMO_W'(1);
    err_d    = err_q;
    done_d   = 1'b0;
    digest_d = digest_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (START) begin
          state_d = S_LOAD_H1;
          phase_d = PH_ISSUE;
          err_d   = 1'b0;
        end
      end
      S_ERR: begin
        tmo_d   = '0;
        state_d = S_IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        if (phase_q == PH_ISSUE && RDY) begin
          phase_d = PH_RELEASE;
          tmo_d   = '0;
          if (state_q == S_DIGEST) digest_d = RES;
        end else if (phase_q == PH_RELEASE && !RDY) begin
          state_d = succ(state_q);
          phase_d = PH_ISSUE;
          tmo_d   = '0;
          if (state_q == S_DIGEST) done_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          phase_d = PH_ISSUE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cmd_code = CMD_IDLE;
    m_sel    = 2'd0;
    h_sel    = 1'b0;
    case (state_q)
      S_LOAD_H1: cmd_code = CMD_LOAD_H;
      S_HASH1:   cmd_code = CMD_HASH;
      S_SUM1:    cmd_code = CMD_SUM_STORE_H;
      S_LOAD_H2: begin cmd_code = CMD_LOAD_H;      h_sel = 1'b1; end
      S_HASH2:   begin cmd_code = CMD_HASH;        m_sel = 2'd1; end
      S_SUM2:    begin cmd_code = CMD_SUM_STORE_M; m_sel = 2'd1; h_sel = 1'b1; end
      S_LOAD_H3: begin cmd_code = CMD_LOAD_H;      m_sel = 2'd2; end
      S_HASH3:   begin cmd_code = CMD_HASH;        m_sel = 2'd2; end
      S_DIGEST:  begin cmd_code = CMD_GET_DIGEST;  m_sel = 2'd2; end
      default:   ;
    endcase
  end

  // Bank storage: header writes only while idle, core stores only in the SUM issue sub-phases.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q <= H_RST;
      m_q <= M_RST;
    end else begin
      if (HDR_WE && !BUSY && HDR_ADDR < 5'd20) m_q[{1'b0, HDR_ADDR}] <= HDR_DATA;
      if (state_q == S_SUM1 && phase_q == PH_ISSUE) h_q[{2'b01, HA[2:0]}] <= HD_OUT;
      if (state_q == S_SUM2 && phase_q == PH_ISSUE) m_q[{3'b100, HA[2:0]}] <= MD_OUT;
    end
  end

  assign CMD    = (phase_q == PH_ISSUE) ? cmd_code : CMD_IDLE;
  assign BUSY   = (state_q != S_IDLE) && (state_q != S_ERR);
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign DIGEST = digest_q;
  assign KD     = K_ROM[MKA[5:0]];
  assign MD_IN  = m_q[{m_sel, MKA[3:0]}];
  assign HD_IN  = h_q[{1'b0, h_sel, HA[2:0]}];

  assign unused_addr_bits = ^{MKA[7:6], HA[7:3]};

endmodule

// File: tb/tb_sha256d_sequencer.sv
// Directed bench for sha256d_sequencer with a behavioural compression-core model on the command port.
module tb_sha256d_sequencer;

  localparam logic [7:0] C_IDLE = 8'd0, C_LOAD = 8'd1, C_HASH = 8'd2,
                         C_SUMH = 8'd3, C_SUMM = 8'd4, C_DIG  = 8'd5;

  localparam logic [255:0] GEN_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [31:0] HDR [20] = '{
    32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3ba3edfd,
    32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132,
    32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };
  localparam logic [31:0] MID [8] = '{
    32'hbc909a33, 32'h6358bff0, 32'h90ccac7d, 32'h1e59caa8,
    32'hc3c8d8e9, 32'h4f0103c8, 32'h96b18736, 32'h4719f91b
  };
  localparam logic [31:0] FIRST [8] = '{
    32'haf42031e, 32'h805ff493, 32'ha07341e2, 32'hf74ff581,
    32'h49d22ab9, 32'hba19f613, 32'h43e2c86c, 32'h71c5d66d
  };

  logic         CLK = 1'b0;
  logic         RST_N, HDR_WE, START, RDY, BUSY, DONE, ERR;
  logic [4:0]   HDR_ADDR;
  logic [31:0]  HDR_DATA, MD_IN, KD, HD_IN, HD_OUT, MD_OUT;
  logic [255:0] DIGEST, RES;
  logic [7:0]   CMD, MKA, HA, core_mka, core_ha, probe_mka;
  logic         probe_en, stall_hash, core_busy;
  int           checks = 0, failures = 0, done_cnt = 0;

  always #5 CLK = ~CLK;

  assign MKA = probe_en ? probe_mka : core_mka;
  assign HA  = core_ha;

  sha256d_sequencer #(.TIMEOUT_CYC(1024)) dut (
    .CLK(CLK), .RST_N(RST_N), .HDR_WE(HDR_WE), .HDR_ADDR(HDR_ADDR), .HDR_DATA(HDR_DATA),
    .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DIGEST(DIGEST), .CMD(CMD),
    .MKA(MKA), .HA(HA), .MD_IN(MD_IN), .KD(KD), .HD_IN(HD_IN),
    .HD_OUT(HD_OUT), .MD_OUT(MD_OUT), .RES(RES), .RDY(RDY)
  );

  always @(negedge CLK) if (DONE === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  // Compression core: one bank access per cycle, RDY after the work, drop RDY once CMD returns to idle.
  logic [31:0] wv [8];
  logic [31:0] ws [16];
  initial begin : core_model
    logic [31:0] t1, t2, wt, s;
    logic [7:0]  cmd;
    int          n;
    core_mka = '0; core_ha = '0; HD_OUT = '0; MD_OUT = '0; RES = '0; RDY = 1'b0; core_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (CMD !== C_IDLE) begin
        cmd = CMD;
        core_busy = 1'b1;
        if (cmd == C_HASH && stall_hash) begin
          n = 0;
          while (CMD !== C_IDLE && n < 2000) begin @(negedge CLK); n++; end
          stall_hash = 1'b0;
        end else begin
          case (cmd)
            C_LOAD: for (int i = 0; i < 8; i++) begin
              core_ha = 8'(i); #1; wv[3'(i)] = HD_IN; @(negedge CLK);
            end
            C_HASH: for (int t = 0; t < 64; t++) begin
              core_mka = 8'(t); #1;
              if (t < 16) wt = MD_IN;
              else wt = ssig1(ws[4'(t - 2)]) + ws[4'(t - 7)] + ssig0(ws[4'(t - 15)]) + ws[4'(t)];
              ws[4'(t)] = wt;
              t1 = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + KD + wt;
              t2 = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
              wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
              wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
              @(negedge CLK);
            end
            C_SUMH, C_SUMM: for (int i = 0; i < 8; i++) begin
              core_ha = 8'(i); #1;
              s = HD_IN + wv[3'(i)];
              HD_OUT = (cmd == C_SUMH) ? s : ~s;
              MD_OUT = (cmd == C_SUMM) ? s : ~s;
              @(negedge CLK);
            end
            C_DIG: for (int i = 0; i < 8; i++) begin
              core_ha = 8'(i); #1;
              RES = {RES[223:0], HD_IN + wv[3'(i)]};
              @(negedge CLK);
            end
            default: ;
          endcase
          RDY = 1'b1;
          n = 0;
          while (CMD !== C_IDLE && n < 2000) begin @(negedge CLK); n++; end
          RDY = 1'b0;
        end
        core_busy = 1'b0;
      end
    end
  end

  task automatic hdr_write(input logic [4:0] a, input logic [31:0] d);
    HDR_WE = 1'b1; HDR_ADDR = a; HDR_DATA = d;
    @(negedge CLK);
    HDR_WE = 1'b0;
  endtask

  task automatic load_header;
    for (int i = 0; i < 20; i++) hdr_write(5'(i), HDR[5'(i)]);
  endtask

  task automatic start_pulse;
    START = 1'b1; @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < 3000) begin @(negedge CLK); n++; end
    chk({tag, " done"}, 256'(DONE), 256'd1);
  endtask

  task automatic wait_cmd(input logic [7:0] c, input string tag);
    int n = 0;
    while (CMD !== c && n < 2000) begin @(negedge CLK); n++; end
    chk(tag, 256'(CMD), 256'(c));
  endtask

  task automatic run_check(input string tag);
    start_pulse;
    wait_done(tag);
    chk({tag, " digest"}, DIGEST, GEN_DIGEST);
    chk({tag, " busy"}, 256'(BUSY), 256'd0);
    @(negedge CLK);
    chk({tag, " done one cycle"}, 256'(DONE), 256'd0);
  endtask

  initial begin : stimulus
    logic [31:0] acc;
    int          cnt, dn, n;
    RST_N = 1'b0; HDR_WE = 1'b0; HDR_ADDR = '0; HDR_DATA = '0; START = 1'b0;
    probe_en = 1'b0; probe_mka = '0; stall_hash = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst CMD", 256'(CMD), 256'd0);
    chk("rst BUSY", 256'(BUSY), 256'd0);
    chk("rst DONE", 256'(DONE), 256'd0);
    chk("rst ERR", 256'(ERR), 256'd0);
    chk("rst DIGEST", DIGEST, 256'd0);
    chk("rst H0", 256'(dut.h_q[0]), 256'h6a09e667);
    chk("rst H7", 256'(dut.h_q[7]), 256'h5be0cd19);
    chk("rst H8", 256'(dut.h_q[8]), 256'd0);
    chk("rst M0", 256'(dut.m_q[0]), 256'd0);
    chk("rst M40", 256'(dut.m_q[40]), 256'h80000000);
    chk("rst M47", 256'(dut.m_q[47]), 256'h00000100);
    RST_N = 1'b1;
    @(negedge CLK);

    probe_en = 1'b1;
    probe_mka = 8'd0;  #1 chk("KD[0]", 256'(KD), 256'h428a2f98);
    probe_mka = 8'd63; #1 chk("KD[63]", 256'(KD), 256'hc67178f2);
    probe_mka = 8'hC5; #1 chk("KD wrap 0xC5", 256'(KD), 256'h59f111f1);
    probe_en = 1'b0;
    @(negedge CLK);

    hdr_write(5'd20, 32'hffffffff);
    hdr_write(5'd31, 32'hffffffff);
    chk("M20 after addr20 write", 256'(dut.m_q[20]), 256'h80000000);
    chk("M31 after addr31 write", 256'(dut.m_q[31]), 256'h00000280);
    chk("M19 untouched", 256'(dut.m_q[19]), 256'd0);

    load_header;
    run_check("run1");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("H[%0d]", 8 + i), 256'(dut.h_q[5'(8 + i)]), 256'(MID[3'(i)]));
      chk($sformatf("M[%0d]", 32 + i), 256'(dut.m_q[6'(32 + i)]), 256'(FIRST[3'(i)]));
    end

    start_pulse;
    wait_cmd(C_HASH, "busy run hash1");
    START = 1'b1; HDR_WE = 1'b1; HDR_ADDR = 5'd3; HDR_DATA = 32'hdeadbeef;
    @(negedge CLK);
    START = 1'b0; HDR_WE = 1'b0;
    chk("M3 write while busy", 256'(dut.m_q[3]), 256'd0);
    wait_done("busy run");
    chk("busy run digest", DIGEST, GEN_DIGEST);
    repeat (20) @(negedge CLK);
    chk("busy run no restart", 256'(BUSY), 256'd0);

    stall_hash = 1'b1;
    dn = done_cnt;
    start_pulse;
    wait_cmd(C_HASH, "timeout hash1");
    cnt = 0;
    while (ERR !== 1'b1 && cnt < 1200) begin
      if (CMD === C_HASH) cnt++;
      @(negedge CLK);
    end
    chk("timeout cycles", 256'(cnt), 256'd1024);
    chk("timeout ERR", 256'(ERR), 256'd1);
    chk("timeout CMD", 256'(CMD), 256'd0);
    chk("timeout BUSY", 256'(BUSY), 256'd0);
    chk("timeout no DONE", 256'(done_cnt), 256'(dn));
    @(negedge CLK);
    chk("ERR sticky in idle", 256'(ERR), 256'd1);
    start_pulse;
    chk("START clears ERR", 256'(ERR), 256'd0);
    chk("restart BUSY", 256'(BUSY), 256'd1);
    wait_done("after timeout");
    chk("after timeout digest", DIGEST, GEN_DIGEST);
    @(negedge CLK);

    start_pulse;
    wait_cmd(C_HASH, "s5 hash1");
    wait_cmd(C_SUMH, "s5 sum1");
    wait_cmd(C_HASH, "s5 hash2");
    repeat (10) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrun rst CMD", 256'(CMD), 256'd0);
    chk("midrun rst BUSY", 256'(BUSY), 256'd0);
    chk("midrun rst DIGEST", DIGEST, 256'd0);
    acc = '0;
    for (int i = 0; i < 20; i++) acc = acc | dut.m_q[6'(i)];
    chk("midrun rst M[0..19]", 256'(acc), 256'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    n = 0;
    while (core_busy && n < 200) begin @(negedge CLK); n++; end
    chk("core model idle", 256'(core_busy), 256'd0);
    load_header;
    run_check("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256d_sequencer.md
Name: sha256d_sequencer

Overview:
Initiator/host side of the compression core's command protocol. Owns the H bank (24 words), the M bank (48 words) and the K ROM (64 words). Serves the core's MKA/HA read addresses, captures its HD_OUT/MD_OUT stores, and sequences the nine-command double-SHA256 flow over an 80-byte block header. Sits between the mining front-end, which writes header words, and the compression core.

Parameters:
CMD_IDLE, 8'd0, idle command code; must match the core.
CMD_LOAD_H, 8'd1, load a..h from H bank.
CMD_HASH, 8'd2, 64-round hash.
CMD_SUM_STORE_H, 8'd3, add and store to H bank.
CMD_SUM_STORE_M, 8'd4, add and store to M bank.
CMD_GET_DIGEST, 8'd5, present RES.
TIMEOUT_CYC, 1024, maximum cycles per handshake phase before error.

Ports:
CLK  in  1  clock; all state updates on posedge.
RST_N  in  1  asynchronous active-low reset.
HDR_WE  in  1  header word write strobe.
HDR_ADDR  in  5  header word index, 0..19.
HDR_DATA  in  32  header word, big-endian.
START  in  1  start request; single-cycle pulse.
BUSY  out  1  sequence in progress.
DONE  out  1  one-cycle pulse when DIGEST is valid.
ERR  out  1  sticky handshake timeout flag; cleared by START or reset.
DIGEST  out  256  RES captured at GET_DIGEST.
CMD  out  8  command to the core.
MKA  in  8  core M/K word address.
HA  in  8  core H word address, 0..7.
MD_IN  out  32  M word served to the core.
KD  out  32  K[MKA].
HD_IN  out  32  H word served to the core.
HD_OUT  in  32  core sum output for H-bank store.
MD_OUT  in  32  core sum output for M-bank store.
RES  in  256  core digest.
RDY  in  1  core command-complete.

Behaviour:
- Reset values:
  - Outputs: CMD=CMD_IDLE, BUSY=0, DONE=0, ERR=0, DIGEST=0.
  - H[0..7] = SHA-256 IV (6a09e667 .. 5be0cd19). H[8..23] = 0.
  - M[0..19] = 0, M[20] = 80000000, M[21..30] = 0, M[31] = 00000280.
  - M[32..39] = 0, M[40] = 80000000, M[41..46] = 0, M[47] = 00000100.
- Header port: HDR_WE with HDR_ADDR<20 writes M[HDR_ADDR] on posedge. Writes are ignored when BUSY=1 or HDR_ADDR>=20.
- Top-level states: IDLE, LOAD_H1, HASH1, SUM1, LOAD_H2, HASH2, SUM2, LOAD_H3, HASH3, DIGEST, then back to IDLE. ERR is a separate state.
- Commands issued per state:
  - LOAD_H1, LOAD_H3: CMD_LOAD_H.
  - HASH1, HASH2, HASH3: CMD_HASH.
  - SUM1: CMD_SUM_STORE_H.
  - LOAD_H2: CMD_LOAD_H.
  - SUM2: CMD_SUM_STORE_M.
  - DIGEST: CMD_GET_DIGEST.
- IDLE: START moves to LOAD_H1, sets BUSY=1 and clears ERR. START while BUSY=1 is ignored.
- Each command state has two sub-phases:
  - ISSUE: drive the command code until RDY=1 is sampled.
  - RELEASE: drive CMD_IDLE until RDY=0 is sampled, then advance to the next state.
  - Minimum 2 cycles per command.
- Timeout counter resets on every sub-phase entry. If it reaches TIMEOUT_CYC: go to ERR, CMD=CMD_IDLE, ERR=1, BUSY=0. ERR state returns to IDLE on the next cycle; the ERR output stays set.
- Combinational read mux:
  - KD = K[MKA[5:0]].
  - MD_IN = M[MKA[3:0]] in LOAD_H1/HASH1/SUM1/LOAD_H2; M[16+MKA[3:0]] in HASH2/SUM2; M[32+MKA[3:0]] in LOAD_H3/HASH3/DIGEST.
  - HD_IN = H[8+HA[2:0]] in LOAD_H2 and SUM2; otherwise H[HA[2:0]].
- Stores:
  - SUM1 ISSUE sub-phase: H[8+HA[2:0]] <= HD_OUT every cycle.
  - SUM2 ISSUE sub-phase: M[32+HA[2:0]] <= MD_OUT every cycle.
  - Last write per address wins; the core holds valid data before advancing HA.
- DIGEST state: on RDY=1, DIGEST <= RES, and DONE pulses for one cycle on the RELEASE-to-IDLE transition.
- M[32..39] and H[8..15] are not cleared between runs; each run fully overwrites them.
- RST_N low at any time, including mid-command, immediately forces all reset values and CMD_IDLE.

Test Plan:
1. Write genesis header words (01000000 .. 1dac2b7c) to addresses 0..19, pulse START -> after DONE, DIGEST = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000, BUSY=0.
2. Same run, probe the banks -> H[8..15] = bc909a33 6358bff0 90ccac7d 1e59caa8 c3c8d8e9 4f0103c8 96b18736 4719f91b; M[32..39] = af42031e 805ff493 a07341e2 f74ff581 49d22ab9 ba19f613 43e2c86c 71c5d66d.
3. START pulse and HDR_WE to address 3 while BUSY=1 -> both ignored; M[3] and the final DIGEST are unchanged from scenario 1.
4. Core model holds RDY=0 during HASH1 -> after 1024 cycles ERR=1, CMD=0, BUSY=0, DONE never pulses. A following START clears ERR, and the run completes with the scenario 1 digest.
5. Assert RST_N low in the middle of HASH2 -> CMD=0, BUSY=0, DIGEST=0, M[0..19]=0 immediately. Reload the header, START -> scenario 1 digest.
6. HDR_WE with HDR_ADDR=20 or 31 -> M[20] stays 80000000 and M[31] stays 00000280.
